// File: rtl/tw_vga_defs.sv
// Shared VGA-side definitions: coordinate and colour widths, frame size, palette,
// arbiter state encoding and a pointer-width helper.
package tw_vga_defs;

  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [CW-1:0] BLACK     = 3'b000;
  localparam logic [CW-1:0] P1_BLUE   = 3'b001;
  localparam logic [CW-1:0] P2_GREEN  = 3'b010;
  localparam logic [CW-1:0] P3_RED    = 3'b100;
  localparam logic [CW-1:0] P4_YELLOW = 3'b110;
  localparam logic [CW-1:0] WHITE     = 3'b111;

  typedef enum logic [1:0] {
    ARB   = 2'b00,
    CLEAR = 2'b01
  } arb_state_t;

  // A single requester still needs a 1-bit pointer so the port never collapses to zero width.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first active request at or after rr_ptr,
// wrapping modulo N_REQ; returns a one-hot grant and the winner's index.
module rr_pick
  import tw_vga_defs::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    winner,
  output logic             valid
);

  int   idx;
  logic found;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = PW'(idx);
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/plot_port_arbiter.sv
// Round-robin arbiter for the single vga_adapter plot port, with an optional
// full-screen clear sweep enabled by defining PLOT_ARB_CLEAR_EN.
module plot_port_arbiter
  import tw_vga_defs::*;
#(
  parameter int            N_REQ        = 4,
  parameter logic [XW-1:0] X_MAX        = 8'd159,
  parameter logic [YW-1:0] Y_MAX        = 7'd119,
  parameter logic [CW-1:0] CLEAR_COLOUR = 3'b000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [N_REQ-1:0]    req,
  input  logic [XW*N_REQ-1:0] req_x,
  input  logic [YW*N_REQ-1:0] req_y,
  input  logic [CW*N_REQ-1:0] req_colour,
  output logic [N_REQ-1:0]    grant,
  input  logic                clear_start,
  output logic                clear_busy,
  output logic                clear_done,
  output logic [XW-1:0]       x,
  output logic [YW-1:0]       y,
  output logic [CW-1:0]       colour,
  output logic                plot
);

  localparam int            PW       = ptr_width(N_REQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

  arb_state_t    state_reg;
  logic [PW-1:0] rr_ptr_reg;
  logic [XW-1:0] cx_reg;
  logic [YW-1:0] cy_reg;
  logic [XW-1:0] x_reg;
  logic [YW-1:0] y_reg;
  logic [CW-1:0] colour_reg;
  logic          plot_reg;
  logic          clear_busy_reg;
  logic          clear_done_reg;

  logic [XW-1:0] x_arr      [N_REQ];
  logic [YW-1:0] y_arr      [N_REQ];
  logic [CW-1:0] colour_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign x_arr[gi]      = req_x[XW*gi +: XW];
      assign y_arr[gi]      = req_y[YW*gi +: YW];
      assign colour_arr[gi] = req_colour[CW*gi +: CW];
    end
  endgenerate

  logic [N_REQ-1:0] pick_grant;
  logic [PW-1:0]    pick_winner;
  logic             pick_valid;
  logic [PW-1:0]    rr_ptr_next;
  logic             clear_go;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_reg),
    .grant  (pick_grant),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

`ifdef PLOT_ARB_CLEAR_EN
  assign clear_go = (state_reg == ARB) && clear_start;
`else
  logic unused_clear_start;
  assign unused_clear_start = clear_start;
  assign clear_go           = 1'b0;
`endif

  assign rr_ptr_next = (pick_winner == LAST_IDX) ? '0 : pick_winner + 1'b1;

  // A starting sweep wins over requesters, so the grant is suppressed that cycle too.
  assign grant = (resetn && (state_reg == ARB) && !clear_go) ? pick_grant : '0;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ARB;
      rr_ptr_reg     <= '0;
      cx_reg         <= '0;
      cy_reg         <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      colour_reg     <= '0;
      plot_reg       <= 1'b0;
      clear_busy_reg <= 1'b0;
      clear_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        ARB: begin
          clear_done_reg <= 1'b0;
          if (clear_go) begin
            state_reg      <= CLEAR;
            cx_reg         <= '0;
            cy_reg         <= '0;
            clear_busy_reg <= 1'b1;
            plot_reg       <= 1'b0;
          end else if (pick_valid) begin
            x_reg      <= x_arr[pick_winner];
            y_reg      <= y_arr[pick_winner];
            colour_reg <= colour_arr[pick_winner];
            plot_reg   <= 1'b1;
            rr_ptr_reg <= rr_ptr_next;
          end else begin
            plot_reg <= 1'b0;
          end
        end
        CLEAR: begin
          x_reg      <= cx_reg;
          y_reg      <= cy_reg;
          colour_reg <= CLEAR_COLOUR;
          plot_reg   <= 1'b1;
          // Column-major scan: y runs fastest, x steps when a column completes.
          if (cy_reg == Y_MAX) begin
            cy_reg <= '0;
            if (cx_reg == X_MAX) begin
              cx_reg         <= '0;
              state_reg      <= ARB;
              clear_busy_reg <= 1'b0;
              clear_done_reg <= 1'b1;
            end else begin
              cx_reg <= cx_reg + 1'b1;
            end
          end else begin
            cy_reg <= cy_reg + 1'b1;
          end
        end
        default: state_reg <= ARB;
      endcase
    end
  end

  assign x          = x_reg;
  assign y          = y_reg;
  assign colour     = colour_reg;
  assign plot       = plot_reg;
  assign clear_busy = clear_busy_reg;
  assign clear_done = clear_done_reg;

endmodule

// File: tb/tb_plot_port_arbiter.sv
// Directed testbench for plot_port_arbiter; clear-sweep scenarios run when
// PLOT_ARB_CLEAR_EN is defined, the clear-ignored scenario otherwise.
module tb_plot_port_arbiter;

  logic        CLOCK_50;
  logic        resetn;
  logic [3:0]  req;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [11:0] req_colour;
  logic [3:0]  grant;
  logic        clear_start;
  logic        clear_busy;
  logic        clear_done;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;

  int n_cmp = 0;
  int n_bad = 0;

  plot_port_arbiter dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .req         (req),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_colour  (req_colour),
    .grant       (grant),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic set_slot(input int i, input logic [7:0] xv, input logic [6:0] yv,
                          input logic [2:0] cv);
    req_x[8*i +: 8]      = xv;
    req_y[7*i +: 7]      = yv;
    req_colour[3*i +: 3] = cv;
  endtask

  // Slot i carries (10+i, 20+i, i+1).
  task automatic load_slots();
    for (int i = 0; i < 4; i++) set_slot(i, 8'(10 + i), 7'(20 + i), 3'(i + 1));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req = '0;
    clear_start = 1'b0;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #1 resetn = 1'b1;
  endtask

  task automatic test_reset();
    #7;
    n_cmp++;
    if ({x, y, colour, plot, grant, clear_busy, clear_done} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_init: outputs=%h required 0",
               {x, y, colour, plot, grant, clear_busy, clear_done});
    end
    @(posedge CLOCK_50);
    #1 resetn = 1'b1;
    set_slot(1, 8'd5, 7'd6, 3'd3);
    req = 4'b0010;
    @(posedge CLOCK_50);
    #1 req = 4'b0000;
    n_cmp++;
    if (plot !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_pre_plot: plot=%b required 1", plot);
    end
    #2 resetn = 1'b0;
    req = 4'b1111;
    #1;
    n_cmp++;
    if ({x, y, colour, plot, grant} !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_async: x=%0d y=%0d colour=%b plot=%b grant=%b required all 0",
               x, y, colour, plot, grant);
    end
    @(posedge CLOCK_50);
    #1 resetn = 1'b1;
    req = '0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    load_slots();
    set_slot(2, 8'd40, 7'd30, 3'b100);
    req = 4'b0100;
    #3;
    n_cmp++;
    if (grant !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_grant: grant=%b required 0100", grant);
    end
    @(posedge CLOCK_50);
    #1 req = 4'b0000;
    n_cmp++;
    if ({x, y, colour, plot} !== {8'd40, 7'd30, 3'b100, 1'b1}) begin
      n_bad++;
      $display("FAIL single_pixel: x=%0d y=%0d colour=%b plot=%b required 40 30 100 1",
               x, y, colour, plot);
    end
    @(posedge CLOCK_50);
    #1;
    n_cmp++;
    if ({plot, x} !== {1'b0, 8'd40}) begin
      n_bad++;
      $display("FAIL single_idle: plot=%b x=%0d required plot 0 x 40", plot, x);
    end
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    do_reset();
    load_slots();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #3;
      n_cmp++;
      if (grant !== 4'(1 << (k % 4))) begin
        n_bad++;
        $display("FAIL rr_grant%0d: grant=%b required %b", k, grant, 4'(1 << (k % 4)));
      end
      @(posedge CLOCK_50);
      #1;
      n_cmp++;
      if ({x, y, colour, plot} !== {8'(10 + k % 4), 7'(20 + k % 4), 3'(k % 4 + 1), 1'b1}) begin
        n_bad++;
        $display("FAIL rr_pixel%0d: x=%0d y=%0d colour=%b plot=%b required %0d %0d %0d 1",
                 k, x, y, colour, plot, 10 + k % 4, 20 + k % 4, k % 4 + 1);
      end
    end
    req = 4'b0000;
    $display("test_round_robin done");
  endtask

  // Sparse requests: pointer must skip idle slots and wrap from 3 back to 0.
  task automatic test_sparse();
    logic [3:0] exp_g [3];
    exp_g[0] = 4'b0001;
    exp_g[1] = 4'b1000;
    exp_g[2] = 4'b0001;
    do_reset();
    load_slots();
    req = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      #3;
      n_cmp++;
      if (grant !== exp_g[k]) begin
        n_bad++;
        $display("FAIL sparse_grant%0d: grant=%b required %b", k, grant, exp_g[k]);
      end
      @(posedge CLOCK_50);
      #1;
    end
    req = 4'b0000;
    $display("test_sparse done");
  endtask

`ifdef PLOT_ARB_CLEAR_EN
  task automatic test_clear();
    int bad_pix = 0;
    int bad_ctl = 0;
    int ex = 0;
    int ey = 0;
    do_reset();
    load_slots();
    req = 4'b0011;
    clear_start = 1'b1;
    #3;
    n_cmp++;
    if ({grant, clear_busy} !== 5'b0) begin
      n_bad++;
      $display("FAIL clear_start_cycle: grant=%b busy=%b required 0000 0", grant, clear_busy);
    end
    @(posedge CLOCK_50);
    #1 clear_start = 1'b0;
    for (int n = 1; n <= 19200; n++) begin
      @(posedge CLOCK_50);
      #1;
      if ({x, y, colour, plot} !== {8'(ex), 7'(ey), 3'b000, 1'b1}) bad_pix++;
      if (n < 19200 && {grant, clear_busy, clear_done} !== 6'b000010) bad_ctl++;
      if (n == 1) begin
        n_cmp++;
        if ({x, y, colour, plot} !== {8'd0, 7'd0, 3'b000, 1'b1}) begin
          n_bad++;
          $display("FAIL clear_first: x=%0d y=%0d colour=%b plot=%b required 0 0 000 1",
                   x, y, colour, plot);
        end
      end
      if (n == 19200) begin
        n_cmp++;
        if ({x, y, colour, plot} !== {8'd159, 7'd119, 3'b000, 1'b1}) begin
          n_bad++;
          $display("FAIL clear_last: x=%0d y=%0d colour=%b plot=%b required 159 119 000 1",
                   x, y, colour, plot);
        end
        n_cmp++;
        if ({clear_done, clear_busy, grant} !== 6'b100001) begin
          n_bad++;
          $display("FAIL clear_end: done=%b busy=%b grant=%b required 1 0 0001",
                   clear_done, clear_busy, grant);
        end
      end
      if (ey == 119) begin
        ey = 0;
        ex++;
      end else begin
        ey++;
      end
    end
    n_cmp++;
    if (bad_pix !== 0) begin
      n_bad++;
      $display("FAIL clear_scan: %0d bad pixel cycles, required 0", bad_pix);
    end
    n_cmp++;
    if (bad_ctl !== 0) begin
      n_bad++;
      $display("FAIL clear_ctl: %0d cycles with bad grant/busy/done, required 0", bad_ctl);
    end
    @(posedge CLOCK_50);
    #1;
    n_cmp++;
    if ({x, y, colour, plot, clear_done, grant} !== {8'd10, 7'd20, 3'd1, 1'b1, 1'b0, 4'b0010}) begin
      n_bad++;
      $display("FAIL clear_resume: x=%0d y=%0d colour=%b plot=%b done=%b grant=%b required 10 20 001 1 0 0010",
               x, y, colour, plot, clear_done, grant);
    end
    req = 4'b0000;
    $display("test_clear done");
  endtask

  task automatic test_clear_restart();
    int cnt = 0;
    do_reset();
    clear_start = 1'b1;
    @(posedge CLOCK_50);
    #1 clear_start = 1'b0;
    while (clear_done !== 1'b1 && cnt < 20000) begin
      @(posedge CLOCK_50);
      #1;
      cnt++;
      clear_start = (cnt == 500);
    end
    clear_start = 1'b0;
    n_cmp++;
    if (cnt !== 19200) begin
      n_bad++;
      $display("FAIL clear_restart_len: done after %0d cycles required 19200", cnt);
    end
    @(posedge CLOCK_50);
    #1;
    n_cmp++;
    if ({clear_done, clear_busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL clear_restart_after: done=%b busy=%b required 0 0", clear_done, clear_busy);
    end
    $display("test_clear_restart done");
  endtask

  task automatic test_reset_in_clear();
    int bad = 0;
    do_reset();
    clear_start = 1'b1;
    @(posedge CLOCK_50);
    #1 clear_start = 1'b0;
    repeat (100) @(posedge CLOCK_50);
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({clear_busy, clear_done, plot} !== 3'b000) begin
      n_bad++;
      $display("FAIL abort_reset: busy=%b done=%b plot=%b required 0 0 0",
               clear_busy, clear_done, plot);
    end
    @(posedge CLOCK_50);
    #1 resetn = 1'b1;
    req = 4'b0001;
    #3;
    n_cmp++;
    if (grant !== 4'b0001) begin
      n_bad++;
      $display("FAIL abort_grant: grant=%b required 0001", grant);
    end
    req = 4'b0000;
    repeat (20) begin
      @(posedge CLOCK_50);
      #1;
      if ({clear_busy, clear_done} !== 2'b00) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL abort_quiet: %0d cycles with busy/done set, required 0", bad);
    end
    $display("test_reset_in_clear done");
  endtask
`else
  task automatic test_no_clear();
    int bad = 0;
    do_reset();
    load_slots();
    req = 4'b0001;
    clear_start = 1'b1;
    #3;
    n_cmp++;
    if ({grant, clear_busy} !== 5'b00010) begin
      n_bad++;
      $display("FAIL noclear_grant: grant=%b busy=%b required 0001 0", grant, clear_busy);
    end
    @(posedge CLOCK_50);
    #1 clear_start = 1'b0;
    req = 4'b0000;
    n_cmp++;
    if ({x, y, colour, plot} !== {8'd10, 7'd20, 3'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL noclear_pixel: x=%0d y=%0d colour=%b plot=%b required 10 20 001 1",
               x, y, colour, plot);
    end
    repeat (5) begin
      @(posedge CLOCK_50);
      #1;
      if ({clear_busy, clear_done} !== 2'b00) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL noclear_busy: %0d cycles with busy/done set, required 0", bad);
    end
    $display("test_no_clear done");
  endtask
`endif

  initial begin
    resetn      = 1'b0;
    req         = '0;
    req_x       = '0;
    req_y       = '0;
    req_colour  = '0;
    clear_start = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_sparse();
`ifdef PLOT_ARB_CLEAR_EN
    test_clear();
    test_clear_restart();
    test_reset_in_clear();
`else
    test_no_clear();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
